// File: rtl/digit_scan_driver.sv
// digit_scan_driver
//   Time-multiplexed 7-segment driver for NUM_DIGITS common digits sharing one
//   segment bus. Hex decode, per-digit dp/blank/blink, leading-zero
//   suppression, dead time between digit slots, selectable polarity and
//   frame-synchronous double-buffered loading.
//
// Ports
//   CLK            system clock
//   RSTn           asynchronous active-low reset
//   Digit_Data     nibble k = value of digit k (digit 0 = rightmost)
//   Dp_Mask        1 = decimal point of digit k lit
//   Blank_Mask     1 = digit k always dark
//   Blink_Mask     1 = digit k dark during blink-off phase
//   Lz_Suppress    1 = leading-zero suppression enabled (live, not buffered)
//   Load           one-cycle strobe: capture data and masks into pending buffer
//   Digitron_Out   segments {dp,g,f,e,d,c,b,a}, registered
//   DigitronCS_Out one-hot digit selects, registered
//   Frame_Pulse    one-cycle pulse after the display buffer was updated
//
// Handshake: Load is a bare strobe with no ready; the pending buffer always
// accepts and the latest Load before a frame boundary wins.
module digit_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 200,
   parameter int DEAD_CYCLES    = 2,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int CS_ACTIVE_LOW  = 1
) (
   input  logic                      CLK,
   input  logic                      RSTn,
   input  logic [4*NUM_DIGITS-1:0]   Digit_Data,
   input  logic [NUM_DIGITS-1:0]     Dp_Mask,
   input  logic [NUM_DIGITS-1:0]     Blank_Mask,
   input  logic [NUM_DIGITS-1:0]     Blink_Mask,
   input  logic                      Lz_Suppress,
   input  logic                      Load,
   output logic [7:0]                Digitron_Out,
   output logic [NUM_DIGITS-1:0]     DigitronCS_Out,
   output logic                      Frame_Pulse
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0]         CNT_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]         CNT_DEAD = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0]         BLK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [7:0]            SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] CS_INV   = (CS_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_on;

   logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
   logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, pend_blink;
   logic [NUM_DIGITS-1:0]   disp_dp, disp_blank, disp_blink;
   logic                    pend_valid;

   logic                    tick;
   logic                    frame_end;
   logic                    dead;
   logic [NUM_DIGITS:0]     all_zero;
   logic [7:0]              seg_next;
   logic [NUM_DIGITS-1:0]   cs_next;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign tick      = (cnt == CNT_LAST);
   // With a single digit IDX_LAST is 0, so every tick is a frame boundary.
   assign frame_end = tick && (idx == IDX_LAST);
   assign dead      = (cnt < CNT_DEAD);

   always_comb begin
      all_zero             = '0;
      seg_next             = 8'h00;
      cs_next              = '0;
      // all_zero[k]: digits k..NUM_DIGITS-1 of the display buffer are all zero
      all_zero[NUM_DIGITS] = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         all_zero[k] = all_zero[k+1] & (disp_data[4*k +: 4] == 4'h0);
      end
      if (!dead) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
               cs_next[k] = 1'b1;
               // Dark digits keep their select so the scan rhythm is unchanged.
               if (!(disp_blank[k] |
                     (disp_blink[k] & ~blink_on) |
                     (Lz_Suppress & all_zero[k] & (k != 0)))) begin
                  seg_next = {disp_dp[k], hex7(disp_data[4*k +: 4])};
               end
            end
         end
      end
   end

   // Slot prescaler, digit index and blink timing.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt       <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         if (frame_end) begin
            if (blink_cnt == BLK_LAST) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // Double buffer: a Load on the boundary clock goes straight to the display.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_blink <= '0;
         pend_valid <= 1'b0;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
         disp_blink <= '0;
      end else begin
         if (Load) begin
            pend_data  <= Digit_Data;
            pend_dp    <= Dp_Mask;
            pend_blank <= Blank_Mask;
            pend_blink <= Blink_Mask;
            pend_valid <= 1'b1;
         end
         if (frame_end && (pend_valid || Load)) begin
            disp_data  <= Load ? Digit_Data : pend_data;
            disp_dp    <= Load ? Dp_Mask    : pend_dp;
            disp_blank <= Load ? Blank_Mask : pend_blank;
            disp_blink <= Load ? Blink_Mask : pend_blink;
            pend_valid <= 1'b0;
         end
      end
   end

   // Output registers; polarity is applied here, after all darkening.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         Digitron_Out   <= SEG_INV;
         DigitronCS_Out <= CS_INV;
         Frame_Pulse    <= 1'b0;
      end else begin
         Digitron_Out   <= seg_next ^ SEG_INV;
         DigitronCS_Out <= cs_next ^ CS_INV;
         Frame_Pulse    <= frame_end & (pend_valid | Load);
      end
   end

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver
//   Two instances with opposite polarities share all inputs. A reference model
//   derives the scan position from the edge count since reset, tracks the
//   pending/display buffers as plain variables, and derives blink phase from
//   the number of frame boundaries seen.
module tb_digit_scan_driver;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int D  = 2;
   localparam int BF = 2;
   localparam int NUM_CYCLES = 3000;

   logic           CLK = 1'b0;
   logic           RSTn;
   logic [4*N-1:0] d_data;
   logic [N-1:0]   d_dp, d_blank, d_blink;
   logic           d_lz, d_load;

   logic [7:0]     seg_a, seg_b;
   logic [N-1:0]   cs_a, cs_b;
   logic           pulse_a, pulse_b;

   int             n_checks = 0;
   int             n_errors = 0;

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   digit_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(D), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(0), .CS_ACTIVE_LOW(1)
   ) dut_a (
      .CLK(CLK), .RSTn(RSTn), .Digit_Data(d_data), .Dp_Mask(d_dp),
      .Blank_Mask(d_blank), .Blink_Mask(d_blink), .Lz_Suppress(d_lz),
      .Load(d_load), .Digitron_Out(seg_a), .DigitronCS_Out(cs_a),
      .Frame_Pulse(pulse_a)
   );

   digit_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(D), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(1), .CS_ACTIVE_LOW(0)
   ) dut_b (
      .CLK(CLK), .RSTn(RSTn), .Digit_Data(d_data), .Dp_Mask(d_dp),
      .Blank_Mask(d_blank), .Blink_Mask(d_blink), .Lz_Suppress(d_lz),
      .Load(d_load), .Digitron_Out(seg_b), .DigitronCS_Out(cs_b),
      .Frame_Pulse(pulse_b)
   );

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                7'h39, 7'h5E, 7'h79, 7'h71};

   int             e;        // edges since reset release
   int             frames;   // frame boundaries since reset release
   logic [4*N-1:0] m_pdata, m_ddata;
   logic [N-1:0]   m_pdp, m_pblank, m_pblink;
   logic [N-1:0]   m_ddp, m_dblank, m_dblink;
   logic           m_pv;
   logic [7:0]     exp_seg;
   logic [N-1:0]   exp_cs;
   logic           exp_pulse;
   bit             directed;

   task automatic model_reset();
      e = 0; frames = 0;
      m_pdata = '0; m_pdp = '0; m_pblank = '0; m_pblink = '0; m_pv = 1'b0;
      m_ddata = '0; m_ddp = '0; m_dblank = '0; m_dblink = '0;
   endtask

   // Expected pin values after edge e, then buffer bookkeeping for edge e.
   task automatic model_step();
      int   p, ix;
      bit   ph_on, lead, dark;
      logic [3:0] nib;
      p     = e % S;
      ix    = (e / S) % N;
      ph_on = ((frames / BF) % 2) == 0;
      exp_seg = 8'h00;
      exp_cs  = '0;
      if (p >= D) begin
         exp_cs = N'(1 << ix);
         nib    = 4'(m_ddata >> (4 * ix));
         lead   = (ix != 0) && ((m_ddata >> (4 * ix)) == 0);
         dark   = m_dblank[ix] || (m_dblink[ix] && !ph_on) || (d_lz && lead);
         if (!dark) exp_seg = {m_ddp[ix], seg_tab[nib]};
      end
      if (d_load) begin
         m_pdata = d_data; m_pdp = d_dp; m_pblank = d_blank; m_pblink = d_blink;
         m_pv = 1'b1;
      end
      exp_pulse = 1'b0;
      if (p == S - 1 && ix == N - 1) begin
         frames++;
         if (m_pv) begin
            m_ddata = m_pdata; m_ddp = m_pdp; m_dblank = m_pblank; m_dblink = m_pblink;
            m_pv = 1'b0;
            exp_pulse = 1'b1;
         end
      end
      e++;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s edge=%0d got=%02h expected=%02h", tag, e, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_seg_a"},   seg_a,              8'h00);
      check({tag, "_cs_a"},    {4'h0, cs_a},       8'h0F);
      check({tag, "_pulse_a"}, {7'h0, pulse_a},    8'h00);
      check({tag, "_seg_b"},   seg_b,              8'hFF);
      check({tag, "_cs_b"},    {4'h0, cs_b},       8'h00);
      check({tag, "_pulse_b"}, {7'h0, pulse_b},    8'h00);
   endtask

   task automatic check_all();
      check("seg_a",   seg_a,           exp_seg);
      check("cs_a",    {4'h0, cs_a},    {4'h0, ~exp_cs});
      check("pulse_a", {7'h0, pulse_a}, {7'h0, exp_pulse});
      check("seg_b",   seg_b,           ~exp_seg);
      check("cs_b",    {4'h0, cs_b},    {4'h0, exp_cs});
      check("pulse_b", {7'h0, pulse_b}, {7'h0, exp_pulse});
   endtask

   // ---------------- driver ----------------
   function automatic logic [4*N-1:0] rand_data();
      logic [4*N-1:0] v;
      for (int k = 0; k < N; k++) begin
         v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   task automatic load_vals(input logic [4*N-1:0] data, input logic [N-1:0] dp,
                            input logic [N-1:0] blank, input logic [N-1:0] blink,
                            input logic lz);
      d_load = 1'b1; d_data = data; d_dp = dp; d_blank = blank; d_blink = blink;
      d_lz = lz;
   endtask

   task automatic drive();
      // Non-loaded cycles still wiggle data/masks; only Load may capture them.
      d_load  = 1'b0;
      d_data  = 16'($urandom);
      d_dp    = N'($urandom);
      d_blank = N'($urandom);
      d_blink = N'($urandom);
      if (directed) begin
         case (e)
            5:   load_vals(16'h00A5, 4'b0010, 4'b0000, 4'b0000, 1'b0);
            40:  load_vals(16'h1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
            45:  load_vals(16'h2222, 4'b0000, 4'b0000, 4'b0000, 1'b0);
            63:  load_vals(16'h3333, 4'b0000, 4'b0000, 4'b0000, 1'b0); // boundary edge
            100: load_vals(16'h00A5, 4'b0010, 4'b0000, 4'b0000, 1'b1);
            140: load_vals(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
            180: load_vals(16'h0012, 4'b0000, 4'b0100, 4'b0001, 1'b0);
            default: ;
         endcase
         if (e >= 400) directed = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
         load_vals(rand_data(), N'($urandom),
                   ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                   N'($urandom), 1'($urandom_range(0, 1)));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int rst_at;
      RSTn = 1'b0; d_load = 1'b0; d_data = '0; d_dp = '0; d_blank = '0;
      d_blink = '0; d_lz = 1'b0;
      directed = 1'b1;
      model_reset();
      rst_at = $urandom_range(1200, 1800);
      repeat (3) @(negedge CLK);
      check_reset("reset");
      RSTn = 1'b1;

      for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
         if (cyc == rst_at) begin
            d_load = 1'b0;
            RSTn = 1'b0;
            #1;
            check_reset("async_rst");
            repeat (2) @(negedge CLK);
            check_reset("held_rst");
            RSTn = 1'b1;
            model_reset();
         end
         drive();
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         check_all();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
